dmem_ctrl: RTL

Parametrised data memory with a request/response handshake, programmable wait states and byte/halfword/word access. It replaces the single-cycle combinational-read data memory between the data path's load/store unit and backing storage. Each request passes through a small state machine, so the data path can be exercised against slow memory. Sub-word stores and loads are resolved inside the block. Illegal accesses raise an error with the response instead of silently aliasing.

---
 rtl/dmem_pkg.sv | 55 +++++
 rtl/dmem_array.sv | 26 ++
 rtl/dmem_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the wait-stated data memory controller.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Right-aligned store data replicated so every candidate lane carries it.
  function automatic logic [31:0] lane_align(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      SZ_BYTE: d = {4{wdata[7:0]}};
      SZ_HALF: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] lane_extract(input logic [1:0] size, input logic [1:0] lane,
                                               input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] d;
    sh = '0;
    case (size)
      SZ_BYTE: begin
        sh = word >> {lane, 3'b000};
        d  = {24'b0, sh[7:0]};
      end
      SZ_HALF: begin
        sh = word >> {lane[1], 4'b0000};
        d  = {16'b0, sh[15:0]};
      end
      default: d = word;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 storage with byte-enable synchronous write and synchronous read; no reset.
module dmem_array #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic          re,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Request/response data memory: wait-state FSM, request latch, error decode, lane handling.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  output logic        ready,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic        done,
  output logic        err,
  output logic [31:0] read_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LAST = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  state_e      state, state_nxt;
  logic [3:0]  cnt;
  logic        l_we;
  logic [1:0]  l_size;
  logic [31:0] l_addr, l_wdata;
  logic        accept, enter_resp;
  logic        c_we, c_err;
  logic [1:0]  c_size;
  logic [31:0] c_addr, c_wdata;
  logic        err_q, rd_valid;
  logic [1:0]  r_size, r_lane;
  logic [31:0] arr_q;

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (req) state_nxt = (WAIT == 0) ? RESP : BUSY;
      end
      BUSY: if (cnt == WAIT_LAST) state_nxt = RESP;
      RESP: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept     = (state == IDLE) && req;
  assign enter_resp = (state_nxt == RESP);

  // With WAIT=0 the response edge is the accept edge, so the live inputs are used there.
  always_comb begin
    if (state == IDLE) begin
      c_we    = we;
      c_size  = size;
      c_addr  = addr;
      c_wdata = write_data;
    end else begin
      c_we    = l_we;
      c_size  = l_size;
      c_addr  = l_addr;
      c_wdata = l_wdata;
    end
    c_err = (c_size == 2'b11)
         || ((c_size == SZ_HALF) && c_addr[0])
         || ((c_size == SZ_WORD) && (c_addr[1:0] != 2'b00))
         || ({2'b00, c_addr[31:2]} >= DEPTH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      l_we     <= 1'b0;
      l_size   <= '0;
      l_addr   <= '0;
      l_wdata  <= '0;
      err_q    <= 1'b0;
      rd_valid <= 1'b0;
      r_size   <= '0;
      r_lane   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt     <= '0;
        l_we    <= we;
        l_size  <= size;
        l_addr  <= addr;
        l_wdata <= write_data;
      end else if (state == BUSY) begin
        cnt <= cnt + 4'd1;
      end
      if (enter_resp) begin
        err_q    <= c_err;
        rd_valid <= !c_err && !c_we;
        r_size   <= c_size;
        r_lane   <= c_addr[1:0];
      end
    end
  end

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (enter_resp && c_we && !c_err),
    .be    (byte_en(c_size, c_addr[1:0])),
    .re    (enter_resp && !c_we && !c_err),
    .idx   (c_addr[AW+1:2]),
    .wdata (lane_align(c_size, c_wdata)),
    .rdata (arr_q)
  );

  // Array output holds between reads; rd_valid masks it after reset, stores and errors.
  assign read_data = rd_valid ? lane_extract(r_size, r_lane, arr_q) : '0;
  assign err       = err_q;

endmodule
